// File: rtl/branch_sequencer_pkg.sv
// Shared constants for the branch sequencer: opcode encodings, FSM states and the default PC increment.
package branch_sequencer_pkg;

  localparam logic [2:0] OP_BR  = 3'b000;
  localparam logic [2:0] OP_BMI = 3'b001;
  localparam logic [2:0] OP_BPL = 3'b010;
  localparam logic [2:0] OP_BZ  = 3'b011;

  localparam int unsigned DEFAULT_PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_BZ;
  endfunction

endpackage

// File: rtl/branch_sequencer_comparator.sv
// Pure combinational branch condition evaluator; illegal opcodes evaluate to not-taken.
module branch_comparator
  import branch_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  output logic        cond
);

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BR:   cond = 1'b1;
      OP_BMI:  cond = rs[31];
      OP_BPL:  cond = ~rs[31] & (|rs);
      OP_BZ:   cond = ~(|rs);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch controller: accept, evaluate, commit one PC write, then optionally flush.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned PC_INC       = DEFAULT_PC_INC,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      pc_cur,
  input  logic [31:0]      br_offset,
  input  logic             stall_in,
  output logic             pc_we,
  output logic [31:0]      pc_next,
  output logic             taken,
  output logic             illegal,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [31:0]   rs_q, pc_q, off_q;
  logic          cond_q, illegal_q;
  logic [FW-1:0] flush_cnt;
  logic          cmp_cond, eval_illegal, eval_cond;
  logic          accept, commit_fire;

  branch_comparator u_cmp (
    .op   (op_q),
    .rs   (rs_q),
    .cond (cmp_cond)
  );

  assign eval_illegal = is_illegal_op(op_q);
  assign eval_cond    = cmp_cond & ~eval_illegal;
  assign accept       = br_valid & br_ready;
  assign commit_fire  = (state == COMMIT) & ~stall_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = EVAL;
      EVAL:   state_nxt = COMMIT;
      COMMIT: if (!stall_in) state_nxt = (cond_q && FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:  if (flush_cnt <= FW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    br_ready = (state == IDLE) & ~stall_in;
    pc_we    = commit_fire;
    taken    = commit_fire & cond_q;
    illegal  = commit_fire & illegal_q;
    flush    = (state == FLUSH);
    busy     = (state != IDLE);
  end

  // pc_next doubles as the registered target, so it holds its value outside COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      rs_q        <= '0;
      pc_q        <= '0;
      off_q       <= '0;
      cond_q      <= 1'b0;
      illegal_q   <= 1'b0;
      pc_next     <= '0;
      flush_cnt   <= '0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= br_op;
            rs_q  <= rs_val;
            pc_q  <= pc_cur;
            off_q <= br_offset;
          end
        end
        EVAL: begin
          cond_q    <= eval_cond;
          illegal_q <= eval_illegal;
          pc_next   <= eval_cond ? (pc_q + off_q) : (pc_q + 32'(PC_INC));
        end
        COMMIT: begin
          if (!stall_in) begin
            flush_cnt <= FW'(FLUSH_CYCLES);
            if (br_count != '1) br_count <= br_count + CNT_W'(1);
            if (cond_q && taken_count != '1) taken_count <= taken_count + CNT_W'(1);
          end
        end
        FLUSH: flush_cnt <= flush_cnt - FW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer; a CNT_W=4 copy shares the stimulus for saturation checks.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [31:0] rs_val, pc_cur, br_offset;
  logic        stall_in;

  logic        br_ready, pc_we, taken, illegal, flush, busy;
  logic [31:0] pc_next;
  logic [15:0] br_count, taken_count;

  logic        br_ready4, pc_we4, taken4, illegal4, flush4, busy4;
  logic [31:0] pc_next4;
  logic [3:0]  br_count4, taken_count4;

  int errors = 0;
  int checks = 0;
  int exp_br = 0;
  int exp_tk = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.PC_INC(4), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
    .rs_val(rs_val), .pc_cur(pc_cur), .br_offset(br_offset), .stall_in(stall_in),
    .pc_we(pc_we), .pc_next(pc_next), .taken(taken), .illegal(illegal), .flush(flush),
    .busy(busy), .br_count(br_count), .taken_count(taken_count)
  );

  branch_sequencer #(.PC_INC(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready4), .br_op(br_op),
    .rs_val(rs_val), .pc_cur(pc_cur), .br_offset(br_offset), .stall_in(stall_in),
    .pc_we(pc_we4), .pc_next(pc_next4), .taken(taken4), .illegal(illegal4), .flush(flush4),
    .busy(busy4), .br_count(br_count4), .taken_count(taken_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; leaves the DUT back in IDLE with inputs quiet.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] pc, input logic [31:0] off,
                       input logic [31:0] exp_pc, input logic exp_taken,
                       input logic exp_ill, input int stall_n);
    br_valid = 1'b1; br_op = op; rs_val = rs; pc_cur = pc; br_offset = off; stall_in = 1'b0;
    #1 chk({tag, "_ready"}, 32'(br_ready), 32'd1);
    tick();
    br_valid = 1'b0; br_op = 3'b111; rs_val = 32'hDEAD_BEEF; pc_cur = '0; br_offset = '0;
    #1 chk({tag, "_eval_we"}, {29'd0, pc_we, taken, busy}, 32'b001);
    tick();
    for (int i = 0; i < stall_n; i++) begin
      stall_in = 1'b1;
      #1 chk({tag, "_stall_we"}, {30'd0, pc_we, busy}, 32'b01);
      tick();
    end
    stall_in = 1'b0;
    #1;
    chk({tag, "_we"}, 32'(pc_we), 32'd1);
    chk({tag, "_pc"}, pc_next, exp_pc);
    chk({tag, "_taken_ill"}, {30'd0, taken, illegal}, {30'd0, exp_taken, exp_ill});
    exp_br++;
    if (exp_taken) exp_tk++;
    tick();
    chk({tag, "_single_we"}, 32'(pc_we), 32'd0);
    chk({tag, "_brcnt"}, 32'(br_count), 32'(exp_br));
    chk({tag, "_tkcnt"}, 32'(taken_count), 32'(exp_tk));
    if (exp_taken) begin
      chk({tag, "_flush1"}, {30'd0, flush, br_ready}, 32'b10);
      tick();
      chk({tag, "_flush2"}, {30'd0, flush, br_ready}, 32'b10);
      tick();
    end
    chk({tag, "_idle"}, {29'd0, flush, busy, br_ready}, 32'b001);
    chk({tag, "_pc_hold"}, pc_next, exp_pc);
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_op = '0; rs_val = '0; pc_cur = '0; br_offset = '0; stall_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ctrl", {26'd0, pc_we, taken, illegal, flush, busy, br_ready}, 32'b000001);
    chk("rst_pc", pc_next, 32'h0);
    chk("rst_cnt", {br_count, taken_count}, 32'h0);

    issue("br_fwd",   3'b000, 32'h0,         32'h100,       32'h20,       32'h120,       1'b1, 1'b0, 0);
    issue("bpl_zero", 3'b010, 32'h0,         32'h200,       32'h40,       32'h204,       1'b0, 1'b0, 0);
    issue("bz_zero",  3'b011, 32'h0,         32'h300,       32'h40,       32'h340,       1'b1, 1'b0, 0);
    issue("bmi_neg",  3'b001, 32'h8000_0000, 32'h400,       32'h10,       32'h410,       1'b1, 1'b0, 0);
    issue("bpl_pos",  3'b010, 32'h5,         32'h500,       32'h8,        32'h508,       1'b1, 1'b0, 0);
    issue("bmi_pos",  3'b001, 32'h1,         32'h520,       32'h8,        32'h524,       1'b0, 1'b0, 0);
    issue("bz_nz",    3'b011, 32'hFFFF_FFFF, 32'h540,       32'h8,        32'h544,       1'b0, 1'b0, 0);
    issue("br_wrap",  3'b000, 32'h0,         32'hFFFF_FFF0, 32'h20,       32'h0000_0010, 1'b1, 1'b0, 0);
    issue("br_back",  3'b000, 32'h0,         32'h100,       32'hFFFF_FFF0, 32'hF0,       1'b1, 1'b0, 0);
    issue("illegal",  3'b101, 32'h0,         32'h600,       32'h40,       32'h604,       1'b0, 1'b1, 0);
    issue("stall3",   3'b000, 32'h0,         32'h700,       32'h30,       32'h730,       1'b1, 1'b0, 3);

    // Request while stalled in IDLE must not be accepted
    br_valid = 1'b1; br_op = 3'b000; pc_cur = 32'h800; br_offset = 32'h8; stall_in = 1'b1;
    #1 chk("idle_stall_ready", 32'(br_ready), 32'd0);
    tick();
    chk("idle_stall_busy", 32'(busy), 32'd0);
    br_valid = 1'b0; stall_in = 1'b0;
    tick();
    chk("idle_stall_cnt", 32'(br_count), 32'(exp_br));

    // Reset in the middle of a flush window
    br_valid = 1'b1; br_op = 3'b000; rs_val = '0; pc_cur = 32'h900; br_offset = 32'h10;
    tick();
    br_valid = 1'b0;
    tick();
    chk("rstf_we", 32'(pc_we), 32'd1);
    tick();
    chk("rstf_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstf_ctrl", {29'd0, flush, busy, pc_we}, 32'b000);
    chk("rstf_cnt", {br_count, taken_count}, 32'h0);
    chk("rstf_pc", pc_next, 32'h0);
    rst = 1'b0;
    exp_br = 0;
    exp_tk = 0;
    #1;

    for (int i = 0; i < 20; i++) begin
      issue("sat", 3'b000, 32'h0, 32'h1000, 32'h40, 32'h1040, 1'b1, 1'b0, 0);
    end
    chk("sat_br16", 32'(br_count), 32'd20);
    chk("sat_br4", 32'(br_count4), 32'd15);
    chk("sat_tk4", 32'(taken_count4), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle branch controller between the decode stage and the PC register. It accepts one branch request at a time, latches its operands and evaluates the branch condition (BR/BMI/BPL/BZ). It then issues a single PC write with either the target or the fall-through address, and asserts a flush window after taken branches. It also keeps saturating branch and taken-branch counters for debug.

Parameters:
PC_INC, 4, fall-through increment added to the latched PC
FLUSH_CYCLES, 2, cycles that flush is held after a taken branch; 0 disables the FLUSH state
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
br_valid  in  1  decode presents a branch request
br_ready  out  1  sequencer can accept a request this cycle
br_op  in  3  000 BR, 001 BMI, 010 BPL, 011 BZ, 100-111 illegal
rs_val  in  32  register operand tested by the condition
pc_cur  in  32  PC of the branch instruction
br_offset  in  32  signed byte offset added to pc_cur when taken
stall_in  in  1  PC stage cannot accept a write this cycle
pc_we  out  1  one-cycle PC write strobe
pc_next  out  32  PC value, valid while pc_we=1
taken  out  1  condition result, valid while pc_we=1
illegal  out  1  pulses with pc_we when br_op is illegal
flush  out  1  squash younger instructions
busy  out  1  state != IDLE
br_count  out  CNT_W  committed branches, saturating
taken_count  out  CNT_W  committed taken branches, saturating

Behaviour:
- Reset values: state IDLE; pc_we, taken, illegal, flush and busy = 0; pc_next = 0; both counters = 0; all latches = 0.
- States: IDLE, EVAL, COMMIT, FLUSH.
- br_ready = (state==IDLE) & ~stall_in, combinational.
- IDLE: on br_valid & br_ready, latch br_op, rs_val, pc_cur and br_offset, then go to EVAL. Inputs are ignored in every other state.
- EVAL (exactly 1 cycle): register the condition result cond from the latched operands.
  - BR: cond = 1.
  - BMI: cond = rs[31].
  - BPL: cond = ~rs[31] & (rs != 0), i.e. strictly positive.
  - BZ: cond = (rs == 0).
  - Illegal op: cond = 0 and the illegal flag is set.
  - Also register target = pc + offset (mod 2^32) when cond=1, else pc + PC_INC (mod 2^32).
  - Go to COMMIT.
- COMMIT:
  - While stall_in=1: hold state, pc_we=0.
  - First cycle with stall_in=0: pc_we=1, pc_next=target, taken=cond, illegal=flag.
  - br_count +1 and, if cond, taken_count +1; both saturate at all-ones.
  - Next state: FLUSH if cond & FLUSH_CYCLES>0, else IDLE.
- pc_next holds its last value outside COMMIT. taken and illegal are 0 whenever pc_we=0.
- FLUSH: flush=1 for exactly FLUSH_CYCLES consecutive cycles, counted by a down-counter loaded in COMMIT, independent of stall_in. Then go to IDLE.
- Minimum latency: accept edge N, pc_we high in cycle N+2, next accept possible in cycle N+3 (not taken) or N+3+FLUSH_CYCLES (taken).
- Simultaneous stall_in and br_valid in IDLE: no accept.
- rst in any state, including mid-COMMIT stall or mid-FLUSH, forces the reset values on the next edge. No partial pc_we or flush pulse is emitted.

Decomposition:
- Shared package holds:
  - branch opcode constants (BR=3'b000, BMI=3'b001, BPL=3'b010, BZ=3'b011);
  - state encoding constants (IDLE, EVAL, COMMIT, FLUSH);
  - the default PC_INC.
- One natural sub-module: instantiate the existing branch_comparator for the condition, fed from the latched op/rs. The sequencer adds the illegal-op override and registers the result.
- Keep the adders, counters and FSM local.

Test Plan:
- BR, pc_cur=0x100, br_offset=0x20, stall_in=0 -> cycle N+2: pc_we=1, pc_next=0x120, taken=1; flush=1 in N+3 and N+4; br_ready high again in N+5; br_count=1, taken_count=1.
- BPL with rs_val=0, pc_cur=0x200 -> pc_next=0x204, taken=0, flush never asserted. BZ with rs_val=0 -> taken=1. BMI with rs_val=0x80000000 -> taken=1.
- BR with pc_cur=0xFFFFFFF0, br_offset=0x20 -> pc_next=0x00000010. BR with br_offset=0xFFFFFFF0 from 0x100 -> pc_next=0xF0.
- br_op=3'b101 -> pc_we with taken=0, illegal=1, pc_next=pc_cur+4; taken_count unchanged.
- stall_in high for 3 cycles on entering COMMIT -> pc_we delayed 3 cycles, single pulse, counters increment once. br_valid with stall_in=1 in IDLE -> no accept.
- rst asserted during the FLUSH of a taken BR -> flush=0 and busy=0 next cycle, counters 0. With CNT_W=4, 20 committed branches -> br_count saturates at 15.
